// File: rtl/add_sum_accum.sv
// add_sum_accum: re-aligns an operand-valid strobe to a pipelined adder's sum, accumulates
// COUNT sums per block and offers each block total through a one-entry valid/ready slot.
module add_sum_accum #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int LAT       = 1,
    parameter int COUNT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     sum,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_ovf,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 overrun
);
    localparam int CW  = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int AW1 = ACC_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    typedef enum logic {EMPTY, FULL} slot_t;
    slot_t state, state_next;

    logic [LAT-1:0]       valid_pipe;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_ovf_run;
    logic [CW-1:0]        count;
    logic                 sample_valid;
    logic                 complete;
    logic                 load;
    logic                 drop;
    logic [AW1-1:0]       add_full;
    logic [ACC_WIDTH-1:0] total;
    logic                 total_ovf;

    assign sample_valid = valid_pipe[LAT-1];
    assign complete     = sample_valid && (count == LAST);
    assign acc_valid    = (state == FULL);

    // sum is only consumed under sample_valid, so an undriven bus never reaches state.
    always_comb begin
        add_full  = {1'b0, acc} + AW1'(sum);
        total     = add_full[ACC_WIDTH-1:0];
        total_ovf = acc_ovf_run | add_full[ACC_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    // Blocks are gapless: the completing sample clears the running state on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            acc_ovf_run <= 1'b0;
            count       <= '0;
        end else if (sample_valid) begin
            if (complete) begin
                acc         <= '0;
                acc_ovf_run <= 1'b0;
                count       <= '0;
            end else begin
                acc         <= total;
                acc_ovf_run <= total_ovf;
                count       <= count + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    state_next = FULL;
                    load       = 1'b1;
                end
            end
            FULL: begin
                if (acc_ready) begin
                    if (complete) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end else if (complete) begin
                    drop = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            acc_out <= '0;
            acc_ovf <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                acc_out <= total;
                acc_ovf <= total_ovf;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add_sum_accum.sv
// Scoreboard bench for add_sum_accum: a LAT-deep adder model feeds the DUT, expected block
// totals are queued at stimulus time and popped by monitors on every output handshake.
module tb_add_sum_accum;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [15:0] x, y;
    logic [15:0] sum;
    logic [23:0] acc_out;
    logic        acc_ovf, acc_valid, acc_ready, overrun;

    logic        in_valid16;
    logic [15:0] x16, y16;
    logic [15:0] sum16;
    logic [15:0] acc_out16;
    logic        acc_ovf16, acc_valid16, acc_ready16, overrun16;

    logic [15:0] add_pipe   [LAT];
    logic [15:0] add_pipe16 [LAT];

    logic [24:0] exp_q[$];
    logic [16:0] exp16_q[$];
    int checks = 0;
    int errors = 0;

    add_sum_accum #(.WIDTH(16), .ACC_WIDTH(24), .LAT(LAT), .COUNT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
        .acc_out(acc_out), .acc_ovf(acc_ovf), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .overrun(overrun)
    );

    add_sum_accum #(.WIDTH(16), .ACC_WIDTH(16), .LAT(LAT), .COUNT(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .sum(sum16),
        .acc_out(acc_out16), .acc_ovf(acc_ovf16), .acc_valid(acc_valid16),
        .acc_ready(acc_ready16), .overrun(overrun16)
    );

    // Adder model: operands sampled at edge k appear on sum for the DUT to sample at k+LAT.
    always @(posedge clk) begin
        add_pipe[0]   <= x + y;
        add_pipe16[0] <= x16 + y16;
        for (int i = 1; i < LAT; i++) begin
            add_pipe[i]   <= add_pipe[i-1];
            add_pipe16[i] <= add_pipe16[i-1];
        end
    end
    assign sum   = add_pipe[LAT-1];
    assign sum16 = add_pipe16[LAT-1];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_block: got %h, expected none", {acc_ovf, acc_out});
            end else begin
                check_output("block_total", {7'd0, acc_ovf, acc_out}, {7'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && acc_valid16 && acc_ready16) begin
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_block16: got %h, expected none",
                         {acc_ovf16, acc_out16});
            end else begin
                check_output("block_total16", {15'd0, acc_ovf16, acc_out16},
                             {15'd0, exp16_q.pop_front()});
            end
        end
    end

    task automatic apply_stimulus(input logic v, input logic [15:0] a, input logic [15:0] b);
        in_valid = v;
        x        = a;
        y        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus16(input logic v, input logic [15:0] a, input logic [15:0] b);
        in_valid16 = v;
        x16        = a;
        y16        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 'x, 'x);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || exp16_q.size() != 0); i++) begin
            @(posedge clk);
        end
        #1;
        check_output(name, exp_q.size() + exp16_q.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        acc_ready  = 1'b1;
        acc_ready16 = 1'b1;
        in_valid16 = 1'b0;
        x16        = 'x;
        y16        = 'x;

        // Reset with random activity on the inputs
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'($urandom), 16'($urandom), 16'($urandom));
        end
        rst = 1'b0;
        idle(1);
        check_output("reset_acc_valid", acc_valid, 0);
        check_output("reset_acc_out", acc_out, 0);
        check_output("reset_acc_ovf", acc_ovf, 0);
        check_output("reset_overrun", overrun, 0);

        // Eight back-to-back 1+1 pairs
        exp_q.push_back({1'b0, 24'h000010});
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 16'h0001, 16'h0001);
        idle(1);
        wait_drain("drain_t2");
        check_output("t2_valid_falls", acc_valid, 0);

        // Toggling valid; the invalid cycles carry a live sum that must be ignored
        exp_q.push_back({1'b0, 24'h07FFF8});
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) apply_stimulus(1'b1, 16'hFFFF, 16'h0000);
            else            apply_stimulus(1'b0, 16'hFFFF, 16'h1234);
        end
        idle(1);
        wait_drain("drain_t3");
        check_output("t3_valid_falls", acc_valid, 0);

        // Consumer stalled through two blocks: first is held, second dropped
        acc_ready = 1'b0;
        exp_q.push_back({1'b0, 24'h000010});
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 16'h0001, 16'h0001);
        idle(3);
        check_output("t4_held_valid", acc_valid, 1);
        check_output("t4_held_out", acc_out, 24'h000010);
        check_output("t4_overrun", overrun, 1);
        acc_ready = 1'b1;
        wait_drain("drain_t4");
        check_output("t4_valid_falls", acc_valid, 0);
        check_output("t4_overrun_sticky", overrun, 1);

        // Partial block, reset pulse with a sum in flight, then a fresh block
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 16'h0100, 16'h0100);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_output("t6_overrun_cleared", overrun, 0);
        check_output("t6_acc_valid", acc_valid, 0);
        check_output("t6_acc_out", acc_out, 0);
        exp_q.push_back({1'b0, 24'h000010});
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 16'h0001, 16'h0001);
        idle(1);
        wait_drain("drain_t6");

        // 16-bit accumulator: wrapping block followed by a gapless clean block
        exp16_q.push_back({1'b1, 16'hFFF8});
        exp16_q.push_back({1'b0, 16'h0010});
        for (int i = 0; i < 8; i++) apply_stimulus16(1'b1, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 8; i++) apply_stimulus16(1'b1, 16'h0001, 16'h0001);
        apply_stimulus16(1'b0, 'x, 'x);
        wait_drain("drain_t5");
        check_output("t5_overrun16", overrun16, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
